spram_access_arbiter: RTL
=========================

SPRAM_ACCESS_ARBITER -- requirements
Module: spram_access_arbiter

Interface
REQ-001 Parameter: depth, default 64, number of RAM words; address width AW = $clog2(depth).
REQ-002 Parameter: width, default 8, data word width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_valid  input  1  write request present.
REQ-006 wr_ready  output  1  write request accepted this cycle.
REQ-007 wr_addr  input  AW  write address.
REQ-008 wr_data  input  width  write data.
REQ-009 rd_valid  input  1  read request present.
REQ-010 rd_ready  output  1  read request accepted this cycle.
REQ-011 rd_addr  input  AW  read address.
REQ-012 rsp_valid  output  1  read response available.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_data  output  width  read response data.
REQ-015 ram_wr_en  output  1  to single-port RAM write enable (No_change mode RAM, 1-cycle registered read).
REQ-016 ram_addr  output  AW  to RAM address.
REQ-017 ram_data_in  output  width  to RAM write data.
REQ-018 ram_data_out  input  width  from RAM read data.

Function
REQ-019 Block SHALL arbitrate one write channel and one read channel onto the single RAM port, at most one access per cycle.
REQ-020 Handshakes: write transfer when wr_valid && wr_ready; read issue when rd_valid && rd_ready; response pop when rsp_valid && rsp_ready.
REQ-021 Read eligibility: rd_elig = (pend + cnt) < 2, where pend = reads issued last cycle, cnt = response FIFO occupancy; no same-cycle credit from a pop.
REQ-022 Grant rules (combinational): only wr_valid -> write; only rd_valid && rd_elig -> read; both and rd_elig -> alternate via last_grant (grant opposite of last_grant); both and !rd_elig -> write.
REQ-023 last_grant SHALL update only on a cycle where a grant occurs; value 0 = read, 1 = write.
REQ-024 ram_wr_en = write granted; ram_addr = wr_addr on write grant, rd_addr on read grant, else holds previous registered value; ram_data_in = wr_data.
REQ-025 Read latency: read issued in cycle N -> pend=1 in N+1 -> ram_data_out captured into FIFO at end of N+1 -> rsp_valid in N+2 at earliest.
REQ-026 Response FIFO: 2 entries, in-order; push on pend, pop on rsp handshake; simultaneous push and pop SHALL keep cnt unchanged.
REQ-027 rsp_data SHALL be the FIFO head, registered; rsp_valid = (cnt != 0); head stable while rsp_valid && !rsp_ready.
REQ-028 FIFO overflow SHALL be impossible by REQ-021; an assertion flags push with cnt == 2 and no pop.
REQ-029 Write then read of same address in a later cycle SHALL return the written data; no same-cycle read-after-write bypass.
REQ-030 Sustained read throughput with rsp_ready=1: one read issued every cycle except when pend + cnt = 2.
REQ-031 Write throughput SHALL be unaffected by response backpressure.

Reset
REQ-032 While rst=1: wr_ready=0, rd_ready=0, rsp_valid=0, rsp_data=0, ram_wr_en=0, ram_addr=0, pend=0, cnt=0, last_grant=0.
REQ-033 Reset mid-operation SHALL discard outstanding reads and buffered responses; no response emitted after deassertion for pre-reset reads.
REQ-034 First grant after reset with both requests valid SHALL be the write.

Verification
REQ-035 Write addr 5 data 0xA5, then read addr 5, rsp_ready=1 -> rsp_valid two cycles after read issue with rsp_data=0xA5.
REQ-036 wr_valid and rd_valid held high 6 cycles, rsp_ready=1 -> grants W,R,W,R,W,R; ram_wr_en=1,0,1,0,1,0.
REQ-037 rsp_ready=0, reads to addrs 1,2,3 -> only two reads issued, rd_ready=0 afterwards, cnt=2, rsp_data holds addr-1 value; raise rsp_ready -> third read issued one cycle after first pop.
REQ-038 rsp_ready=0 with FIFO full, wr_valid pulses to addrs 10..13 -> all four writes accepted back-to-back.
REQ-039 Assert rst one cycle after a read issue -> rsp_valid=0 and cnt=0 after deassertion; no stray response.
REQ-040 Reads 0..63 after writing data=addr^8'h3C, rsp_ready=1 -> 64 in-order responses with matching data.

Source files
------------

// File: rtl/spram_access_arbiter.sv
// rtl/spram_access_arbiter.sv - write/read arbiter onto one single-port RAM with a 2-entry read response FIFO
// Reads are throttled by credits so the response FIFO can never overflow under backpressure.
module spram_access_arbiter #(
    parameter int depth = 64,
    parameter int width = 8,
    localparam int AW = $clog2(depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [width-1:0] wr_data,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [AW-1:0]    rd_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [width-1:0] rsp_data,
    output logic             ram_wr_en,
    output logic [AW-1:0]    ram_addr,
    output logic [width-1:0] ram_data_in,
    input  logic [width-1:0] ram_data_out
);

    logic             pend;
    logic [1:0]       cnt;
    logic             last_grant;
    logic [AW-1:0]    addr_q;
    logic [width-1:0] fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    logic             grant_wr;
    logic             grant_rd;
    logic [1:0]       occ;
    logic             rd_elig;
    logic             push;
    logic             pop;

    // Reads in flight plus buffered responses; pop credit is only seen next cycle.
    assign occ     = cnt + {1'b0, pend};
    assign rd_elig = (occ < 2'd2);

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!rst) begin
            if (wr_valid && rd_valid && rd_elig) begin
                if (last_grant) grant_rd = 1'b1;
                else            grant_wr = 1'b1;
            end else if (wr_valid) begin
                grant_wr = 1'b1;
            end else if (rd_valid && rd_elig) begin
                grant_rd = 1'b1;
            end
        end
    end

    assign wr_ready    = grant_wr;
    assign rd_ready    = grant_rd;
    assign ram_wr_en   = grant_wr;
    assign ram_data_in = wr_data;
    assign ram_addr    = grant_wr ? wr_addr : (grant_rd ? rd_addr : addr_q);

    assign push      = pend;
    assign rsp_valid = (cnt != 2'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend        <= 1'b0;
            cnt         <= 2'd0;
            last_grant  <= 1'b0;
            addr_q      <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            addr_q <= ram_addr;
            pend   <= grant_rd;
            if (grant_wr || grant_rd) last_grant <= grant_wr;
            if (push) begin
                fifo_mem[wr_ptr] <= ram_data_out;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && cnt == 2'd2));

endmodule
